// File: rtl/votn_seq.sv
// Clocked N-voter: one start opens a session, each voter may vote once, the
// session closes when all have voted or the timeout expires; counts and verdict are registered.
module votn_seq #(
  parameter int N       = 5,
  parameter int TIMEOUT = 16,
  localparam int CW     = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  vote_valid,
  input  logic [N-1:0]  vote_val,
  output logic          busy,
  output logic          done,
  output logic          result,
  output logic          tie,
  output logic [CW-1:0] yes_cnt,
  output logic [CW-1:0] no_cnt,
  output logic [1:0]    state_dbg
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  mask;
  logic [TW-1:0] timer;

  logic [N-1:0]  acc;
  logic [CW-1:0] yes_nxt;
  logic [CW-1:0] no_nxt;
  logic          all_voted;
  logic          timed_out;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Handshake: vote_valid[i] qualifies vote_val[i] for one cycle; there is no
  // ready, a vote is taken only in COLLECT and only the first one per voter.
  always_comb begin
    acc       = vote_valid & ~mask;
    yes_nxt   = yes_cnt + popcnt(acc & vote_val);
    no_nxt    = no_cnt + popcnt(acc & ~vote_val);
    all_voted = &(mask | acc);
    timed_out = (timer == TW'(TIMEOUT - 1));
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 1'b0;
      tie     <= 1'b0;
      yes_cnt <= '0;
      no_cnt  <= '0;
      mask    <= '0;
      timer   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_COLLECT;
            busy    <= 1'b1;
            yes_cnt <= '0;
            no_cnt  <= '0;
            mask    <= '0;
            result  <= 1'b0;
            tie     <= 1'b0;
            timer   <= '0;
          end
        end
        S_COLLECT: begin
          mask    <= mask | acc;
          yes_cnt <= yes_nxt;
          no_cnt  <= no_nxt;
          timer   <= timer + TW'(1);
          // Verdict uses this cycle's votes too, so it is valid alongside done.
          if (all_voted || timed_out) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= (yes_nxt > no_nxt);
            tie    <= (yes_nxt == no_nxt);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_votn_seq.sv
// Bench for votn_seq: directed sessions on an N=5 and an N=3 instance, with
// expected verdicts queued at start and checked when done pulses.
module tb_votn_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start3;
  logic [4:0] vv, vl;
  logic [2:0] vv3, vl3;
  logic       busy, done, result, tie;
  logic [2:0] yes, no;
  logic [1:0] st;
  logic       busy3, done3, result3, tie3;
  logic [1:0] yes3, no3;
  logic [1:0] st3;

  int cyc = 0;
  int start_cyc = 0;
  int start_cyc3 = 0;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp3_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  votn_seq #(.N(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vv), .vote_val(vl),
    .busy(busy), .done(done), .result(result), .tie(tie),
    .yes_cnt(yes), .no_cnt(no), .state_dbg(st)
  );

  votn_seq #(.N(3), .TIMEOUT(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .vote_valid(vv3), .vote_val(vl3),
    .busy(busy3), .done(done3), .result(result3), .tie(tie3),
    .yes_cnt(yes3), .no_cnt(no3), .state_dbg(st3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {result, tie, yes, no, done cycle relative to the start edge}
  function automatic logic [15:0] pk(input logic r, input logic t, input int y,
                                     input int n, input int lat);
    return {r, t, 3'(y), 3'(n), 8'(lat)};
  endfunction

  // Monitors
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) check("done5_unexpected", 32'(done), 32'd0);
      else check("session5", {result, tie, yes, no, 8'(cyc - start_cyc)}, exp_q.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && done3 === 1'b1) begin
      if (exp3_q.size() == 0) check("done3_unexpected", 32'(done3), 32'd0);
      else check("session3", {result3, tie3, 1'b0, yes3, 1'b0, no3, 8'(cyc - start_cyc3)},
                 exp3_q.pop_front());
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start5(input bit expect_done, input logic [15:0] e);
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    if (expect_done) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic vote5(input logic [4:0] v, input logic [4:0] x);
    vv = v;
    vl = x;
    @(negedge clk);
    vv = '0;
    vl = '0;
  endtask

  task automatic start3_session(input logic [2:0] x, input logic [15:0] e);
    @(negedge clk);
    start3 = 1'b1;
    start_cyc3 = cyc;
    exp3_q.push_back(e);
    @(negedge clk);
    start3 = 1'b0;
    vv3 = 3'b111;
    vl3 = x;
    @(negedge clk);
    vv3 = '0;
    vl3 = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] maj_tab;
    int ones;
    maj_tab = 8'b1110_1000;

    // Reset with random inputs
    rst_n = 1'b0;
    start = 1'b0; start3 = 1'b0;
    vv = '0; vl = '0; vv3 = '0; vl3 = '0;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      vv    = 5'($urandom_range(0, 31));
      vl    = 5'($urandom_range(0, 31));
      start3 = 1'($urandom_range(0, 1));
      vv3   = 3'($urandom_range(0, 7));
      vl3   = 3'($urandom_range(0, 7));
    end
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_tie", 32'(tie), 32'd0);
    check("rst_yes", 32'(yes), 32'd0);
    check("rst_no", 32'(no), 32'd0);
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
    vv = '0; vl = '0; vv3 = '0; vl3 = '0;
    rst_n = 1'b1;
    idle(3);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(st), 32'd0);

    // Full vote in cycle 1
    start5(1'b1, pk(1, 0, 3, 2, 2));
    vote5(5'b11111, 5'b00111);
    check("busy_cycle2", 32'(busy), 32'd0);
    idle(2);
    check("result_held", 32'(result), 32'd1);
    check("yes_held", 32'(yes), 32'd3);

    // First vote wins
    start5(1'b1, pk(0, 0, 1, 4, 4));
    vote5(5'b00001, 5'b00001);
    vote5(5'b00001, 5'b00000);
    vote5(5'b11110, 5'b00000);
    idle(2);

    // Timeout tie; votes in the DONE cycle are ignored
    start5(1'b1, pk(0, 1, 1, 1, 17));
    vote5(5'b00000, 5'b00000);
    vote5(5'b00010, 5'b00010);
    idle(2);
    vote5(5'b01000, 5'b00000);
    idle(11);
    vote5(5'b11111, 5'b11111);
    check("tto_yes_held", 32'(yes), 32'd1);
    check("tto_no_held", 32'(no), 32'd1);
    check("tto_tie_held", 32'(tie), 32'd1);
    idle(1);

    // Zero votes at timeout
    start5(1'b1, pk(0, 1, 0, 0, 17));
    idle(17);
    check("zero_busy", 32'(busy), 32'd0);
    idle(1);

    // Second start in cycle 3 must not restart the timer
    start5(1'b1, pk(0, 1, 0, 0, 17));
    idle(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(15);

    // Abort by reset mid-session, then a clean session
    start5(1'b0, '0);
    idle(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vote5(5'b00011, 5'b00011);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_yes", 32'(yes), 32'd0);
    check("abort_state", 32'(st), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    start5(1'b1, pk(0, 0, 2, 3, 2));
    vote5(5'b11111, 5'b11000);
    idle(2);

    // N=3 exhaustive majority
    for (int p = 0; p < 8; p++) begin
      ones = $countones(3'(p));
      start3_session(3'(p), pk(maj_tab[p], 0, ones, 3 - ones, 2));
      idle(1);
    end

    idle(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp3_q_drained", 32'(exp3_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/votn_seq.md
# votn_seq

Parametrised, clocked N-voter that succeeds the combinational 3-input majority voter. It runs a timed voting session:
- one start pulse opens the session;
- each of N voters may cast a single yes/no vote;
- the session closes when every voter has voted or a timeout expires.

It then publishes registered yes/no counts, a majority result and a tie flag. It sits between voter input logic (buttons or redundant channels) and the display/decision logic.

## Interface
- N, 5, number of voters (N ≥ 1).
- TIMEOUT, 16, maximum COLLECT cycles per session (TIMEOUT ≥ 1).
- CW, $clog2(N+1), derived count width (localparam).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  single-cycle session request; honoured only in IDLE.
- vote_valid  input  N  bit i high = voter i presents a vote this cycle.
- vote_val  input  N  bit i = vote of voter i (1 = yes, 0 = no); ignored unless vote_valid[i].
- busy  output  1  high while in COLLECT.
- done  output  1  one-cycle pulse when the session closes.
- result  output  1  1 when yes_cnt > no_cnt; held until next start.
- tie  output  1  1 when yes_cnt == no_cnt (including 0 == 0); held until next start.
- yes_cnt  output  CW  yes votes accepted this session.
- no_cnt  output  CW  no votes accepted this session.

## Operation
- FSM states:
  - IDLE → COLLECT on start. Entering COLLECT clears yes_cnt, no_cnt, the voted mask, result, tie and the timer.
  - COLLECT → DONE when all N voters have voted, counting votes accepted in the current cycle, or when the timer reaches TIMEOUT-1.
  - DONE → IDLE unconditionally after one cycle.
- Voted mask (N bits): a vote from voter i is accepted in COLLECT only if vote_valid[i]=1 and mask[i]=0. Acceptance sets mask[i]. Repeated or changed votes are ignored (first vote wins).
- Several voters may vote in the same cycle. Counts increase by the popcount of accepted yes and accepted no bits respectively. The sum never exceeds N, so counts never overflow.
- Votes presented in IDLE or DONE are ignored.
- start in COLLECT or DONE is ignored; no restart.
- On entry to DONE, result and tie are computed from the final counts and registered. done=1 for exactly the DONE cycle. Counts, result and tie hold through IDLE until the next accepted start.
- Zero votes at timeout: yes_cnt=0, no_cnt=0, tie=1, result=0.
- With N=3 and all voters voting in one cycle, result equals the 3-input majority function.

## Timing
- Reset values (asynchronous, while rst_n=0): state=IDLE; busy, done, result, tie = 0; yes_cnt, no_cnt, mask, timer = 0.
- rst_n asserted mid-session aborts immediately: no done pulse, counts cleared.
- Cycle numbering: start sampled high at edge 0.
- busy=1 in cycles 1 to k, where cycle k is the last COLLECT cycle. Votes are sampled at each COLLECT edge.
- All votes in cycle 1: done=1 in cycle 2, with counts/result/tie valid in that same cycle.
- Timeout: the timer counts COLLECT cycles. The session closes after at most TIMEOUT COLLECT cycles, so done occurs no later than cycle TIMEOUT+1.
- A vote arriving in the final COLLECT cycle (timeout cycle) is counted.
- A new start is accepted no earlier than the first IDLE cycle after DONE, i.e. cycle k+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 with random inputs → busy=done=result=tie=0 and yes_cnt=no_cnt=0. Release, no start → state stays IDLE.
- Full vote (N=5, TIMEOUT=16): start, then cycle 1 vote_valid=5'b11111, vote_val=5'b00111 → done in cycle 2, yes_cnt=3, no_cnt=2, result=1, tie=0, busy low from cycle 2.
- First-vote-wins: voter0 votes 1 in cycle 1 and 0 in cycle 2; others vote 0 in cycle 3 → yes_cnt=1, no_cnt=4, result=0, done in cycle 4.
- Timeout tie: only voter1=1 (cycle 2) and voter3=0 (cycle 5) → done in cycle 17, yes_cnt=1, no_cnt=1, tie=1, result=0. Votes presented in cycle 17 are not counted.
- Abort and ignore: start, then start again in cycle 3 (ignored, timer not reset), then rst_n pulse in cycle 5 → no done pulse, all outputs 0, next start begins a clean session.
- N=3 exhaustive: for all 8 vote_val patterns cast in one cycle → result matches the majority truth table and tie=0.
